// File: rtl/pwm_bank_pkg.sv
// pwm_bank_pkg: shared mode encoding and default widths for the PWM bank
package pwm_bank_pkg;
  typedef enum logic {MODE_EDGE = 1'b0, MODE_CENTER = 1'b1} mode_e;
  localparam int DEF_NUM_CH = 16;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_PRE_W = 8;
endpackage

// File: rtl/pwm_bank_timebase.sv
// pwm_bank_timebase: prescaler, edge/center counter and period boundary generation
module pwm_bank_timebase
  import pwm_bank_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PRE_W-1:0] prescale_i,
  input  logic [CNT_W-1:0] period_i,
  input  mode_e            mode_i,
  input  logic             load_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             update_o,
  output logic             period_start_o
);
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic down_q, down_d, ps_q, tick, at_top, boundary, update;
  always_comb begin
    tick = pre_q == prescale_i;
    at_top = cnt_q == period_i;
    boundary = tick && (period_i == '0 || (mode_i == MODE_EDGE ? at_top : down_q && cnt_q == '0));
    update = load_i || boundary;
    pre_d = load_i || tick ? '0 : pre_q + PRE_W'(1);
    cnt_d = update ? '0 : !tick ? cnt_q : mode_i == MODE_EDGE ? cnt_q + CNT_W'(1) :
            down_q ? cnt_q - CNT_W'(1) : at_top ? cnt_q : cnt_q + CNT_W'(1);
    down_d = update ? 1'b0 : tick && mode_i == MODE_CENTER && at_top ? 1'b1 : down_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      cnt_q <= '0;
      down_q <= 1'b0;
      ps_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      down_q <= down_d;
      ps_q <= update;
    end
  end
  assign cnt_o = cnt_q;
  assign update_o = update;
  assign period_start_o = ps_q;
endmodule

// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM with shadowed duty/period/mode and a shared timebase
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W = DEF_CNT_W,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       out_en,
  input  logic [NUM_CH-1:0]       pwm_en,
  input  logic [NUM_CH*CNT_W-1:0] duty,
  input  logic [CNT_W-1:0]        period,
  input  logic [PRE_W-1:0]        prescale,
  input  logic                    mode,
  input  logic                    load,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic [CNT_W-1:0]        cnt,
  output logic                    period_start
);
  logic [NUM_CH-1:0][CNT_W-1:0] duty_sh_q;
  logic [CNT_W-1:0] period_sh_q;
  mode_e mode_sh_q;
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic update;
  pwm_bank_timebase #(.CNT_W(CNT_W), .PRE_W(PRE_W)) u_timebase (
    .clk(clk),
    .rst(rst),
    .prescale_i(prescale),
    .period_i(period_sh_q),
    .mode_i(mode_sh_q),
    .load_i(load),
    .cnt_o(cnt),
    .update_o(update),
    .period_start_o(period_start)
  );
  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < NUM_CH; i++)
      pwm_d[i] = !out_en[i] ? 1'b0 : !pwm_en[i] ? 1'b1 : cnt < duty_sh_q[i];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_sh_q <= '0;
      period_sh_q <= '0;
      mode_sh_q <= MODE_EDGE;
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_d;
      if (update) begin
        duty_sh_q <= duty;
        period_sh_q <= period;
        mode_sh_q <= mode_e'(mode);
      end
    end
  end
  assign pwm_out = pwm_q;
endmodule

// File: tb/tb_pwm_bank.sv
// tb_pwm_bank: scoreboard bench with a period-phase reference model of the PWM bank
module tb_pwm_bank;
  localparam int N = 16;
  localparam int W = 8;
  localparam int PW = 8;
  logic clk = 1'b0;
  logic rst, load, mode;
  logic [N-1:0] out_en, pwm_en;
  logic [N*W-1:0] duty;
  logic [W-1:0] period;
  logic [PW-1:0] prescale;
  logic [N-1:0] pwm_out;
  logic [W-1:0] cnt;
  logic period_start;
  typedef struct {
    int cnt;
    int ps;
    int pwm;
  } exp_t;
  exp_t sb[$];
  exp_t got;
  int n_cmp = 0;
  int n_bad = 0;
  int m_pre = 0, m_k = 0, m_p = 0, m_mode = 0;
  int m_duty[N];
  int h_cnt[$];
  int h_ps[$];
  logic [N-1:0] h_pwm[$];
  pwm_bank u_dut (
    .clk(clk),
    .rst(rst),
    .out_en(out_en),
    .pwm_en(pwm_en),
    .duty(duty),
    .period(period),
    .prescale(prescale),
    .mode(mode),
    .load(load),
    .pwm_out(pwm_out),
    .cnt(cnt),
    .period_start(period_start)
  );
  always #5 clk = ~clk;
  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int cnt_of(int k, int p, int md);
    return (md != 0 && p > 0 && k > p) ? 2 * p + 1 - k : k;
  endfunction
  function automatic int plen(int p, int md);
    return p == 0 ? 1 : md != 0 ? 2 * (p + 1) : p + 1;
  endfunction
  function automatic void take_shadows();
    m_p = int'(period);
    m_mode = int'(mode);
    for (int i = 0; i < N; i++) m_duty[i] = int'(duty[i*W +: W]);
  endfunction
  task automatic step();
    exp_t e;
    logic [N-1:0] pw;
    int c;
    c = cnt_of(m_k, m_p, m_mode);
    for (int i = 0; i < N; i++)
      pw[i] = rst ? 1'b0 : !out_en[i] ? 1'b0 : !pwm_en[i] ? 1'b1 : (c < m_duty[i]);
    e.pwm = int'(pw);
    e.ps = 0;
    if (rst) begin
      m_pre = 0; m_k = 0; m_p = 0; m_mode = 0;
      for (int i = 0; i < N; i++) m_duty[i] = 0;
    end else if (load) begin
      m_pre = 0; m_k = 0; e.ps = 1;
      take_shadows();
    end else if (m_pre == int'(prescale)) begin
      m_pre = 0;
      m_k++;
      if (m_k == plen(m_p, m_mode)) begin
        m_k = 0; e.ps = 1;
        take_shadows();
      end
    end else m_pre = (m_pre + 1) % (1 << PW);
    e.cnt = cnt_of(m_k, m_p, m_mode);
    sb.push_back(e);
    @(posedge clk);
    #2;
  endtask
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      got = sb.pop_front();
      chk("cnt", int'(cnt), got.cnt);
      chk("period_start", int'(period_start), got.ps);
      chk("pwm_out", int'(pwm_out), got.pwm);
      h_cnt.push_back(int'(cnt));
      h_ps.push_back(int'(period_start));
      h_pwm.push_back(pwm_out);
    end
  end
  function automatic int ones(int b, int from, int len);
    int s = 0;
    for (int j = from; j < from + len; j++) s += int'(h_pwm[j][b]);
    return s;
  endfunction
  function automatic int ps_sum(int from, int len);
    int s = 0;
    for (int j = from; j < from + len; j++) s += h_ps[j];
    return s;
  endfunction
  task automatic set_all_duty(int v);
    for (int i = 0; i < N; i++) duty[i*W +: W] = W'(v);
  endtask
  initial begin
    int idx;
    int cseq[10] = '{0, 1, 2, 3, 4, 4, 3, 2, 1, 0};
    rst = 1'b1; load = 1'b0; mode = 1'b0; out_en = '0; pwm_en = '0;
    duty = '0; period = '0; prescale = '0;
    step();
    rst = 1'b0; out_en = '1; pwm_en = '1; period = 8'd9; set_all_duty(5); load = 1'b1;
    step();
    load = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    chk("rst_cnt", int'(cnt), 0);
    chk("rst_pwm", int'(pwm_out), 0);
    chk("rst_ps", int'(period_start), 0);
    duty[W-1:0] = 8'd3; load = 1'b1;
    step();
    load = 1'b0;
    repeat (30) step();
    idx = h_pwm.size() - 20;
    chk("edge_high_per_20", ones(0, idx, 20), 6);
    chk("edge_ps_per_20", ps_sum(idx, 20), 2);
    for (int t = 0; t < 20 && cnt != 8'd5; t++) step();
    chk("wait_cnt5", int'(cnt), 5);
    duty[W-1:0] = 8'd7;
    idx = h_pwm.size();
    repeat (20) step();
    chk("shadow_hold", ones(0, idx, 4), 0);
    chk("shadow_next", ones(0, h_pwm.size() - 10, 10), 7);
    duty[W-1:0] = 8'd0; duty[2*W-1:W] = 8'd10; out_en[2] = 1'b0; pwm_en[3] = 1'b0;
    load = 1'b1;
    step();
    load = 1'b0;
    repeat (20) step();
    idx = h_pwm.size() - 10;
    chk("duty0_low", ones(0, idx, 10), 0);
    chk("duty_gt_p_high", ones(1, idx, 10), 10);
    chk("out_en_low", ones(2, idx, 10), 0);
    chk("pwm_en_high", ones(3, idx, 10), 10);
    out_en = '1; pwm_en = '1; mode = 1'b1; period = 8'd4; set_all_duty(2); load = 1'b1;
    idx = h_cnt.size();
    step();
    load = 1'b0;
    repeat (24) step();
    for (int j = 0; j < 20; j++) chk("center_cnt", h_cnt[idx+j], cseq[j%10]);
    chk("center_high", ones(0, idx + 1, 10), 4);
    chk("center_ps", ps_sum(idx, 10), 1);
    mode = 1'b0; period = 8'd3; prescale = 8'd2; load = 1'b1;
    step();
    load = 1'b0;
    repeat (14) step();
    for (int t = 0; t < 20 && cnt != 8'd2; t++) step();
    chk("wait_cnt2", int'(cnt), 2);
    load = 1'b1;
    idx = h_cnt.size();
    step();
    load = 1'b0;
    chk("load_cnt", int'(cnt), 0);
    chk("load_ps", int'(period_start), 1);
    repeat (14) step();
    chk("pre_hold", h_cnt[idx+2], 0);
    chk("pre_adv", h_cnt[idx+3], 1);
    chk("pre_period_gap", ps_sum(idx + 1, 11), 0);
    chk("pre_period_next", h_ps[idx+12], 1);
    prescale = '0;
    for (int n = 0; n < 700; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      load = ($urandom_range(0, 29) == 0);
      mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) period = W'($urandom_range(0, 12));
      if ($urandom_range(0, 59) == 0) prescale = PW'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < N; i++) duty[i*W +: W] = W'($urandom_range(0, 15));
      out_en = N'($urandom | $urandom);
      pwm_en = N'($urandom | $urandom | $urandom);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
